// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: memory-stage load/store unit with ready handshake, alignment check and load extension
module lsu_mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [4:0]  ex_opcode,
    input  logic [2:0]  ex_func3,
    input  logic [31:0] ex_alu_out,
    input  logic [31:0] ex_rs2_data,
    input  logic [4:0]  ex_rd,
    output logic        lsu_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        lsu_misalign,
    output logic [31:0] lsu_badaddr
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t      state;
    logic [2:0]  func3;
    logic [1:0]  off;
    logic [4:0]  rd;
    logic        is_load, is_store, legal, misaligned, accept;
    logic [3:0]  be;
    logic [31:0] wdata, shifted, load_data;
    always_comb begin
        is_load    = ex_opcode == 5'b00000;
        is_store   = ex_opcode == 5'b01000;
        legal      = is_load ? (ex_func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                             : is_store & (ex_func3 inside {3'b000, 3'b001, 3'b010});
        misaligned = ex_func3[1] ? |ex_alu_out[1:0] : ex_func3[0] & ex_alu_out[0];
        accept     = (state == IDLE) & ex_valid & legal;
        be         = ex_func3[1] ? 4'b1111
                   : ex_func3[0] ? (ex_alu_out[1] ? 4'b1100 : 4'b0011)
                   : 4'b0001 << ex_alu_out[1:0];
        wdata      = ex_func3[1] ? ex_rs2_data
                   : ex_func3[0] ? {2{ex_rs2_data[15:0]}} : {4{ex_rs2_data[7:0]}};
        shifted    = dmem_rdata >> {off, 3'b000};
        // func3[2] selects zero-extension for the unsigned variants
        load_data  = func3[1] ? shifted
                   : func3[0] ? {{16{~func3[2] & shifted[15]}}, shifted[15:0]}
                   : {{24{~func3[2] & shifted[7]}}, shifted[7:0]};
    end
    assign lsu_stall = state == BUSY;
    assign dmem_req  = state == BUSY;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            dmem_we      <= 1'b0;
            dmem_be      <= 4'b0;
            dmem_addr    <= 32'b0;
            dmem_wdata   <= 32'b0;
            wb_valid     <= 1'b0;
            wb_rd        <= 5'b0;
            wb_data      <= 32'b0;
            lsu_misalign <= 1'b0;
            lsu_badaddr  <= 32'b0;
            func3        <= 3'b0;
            off          <= 2'b0;
            rd           <= 5'b0;
        end else begin
            wb_valid     <= 1'b0;
            lsu_misalign <= 1'b0;
            if (state == BUSY) begin
                if (dmem_ready) begin
                    state    <= IDLE;
                    wb_valid <= ~dmem_we;
                    if (!dmem_we) begin
                        wb_rd   <= rd;
                        wb_data <= load_data;
                    end
                end
            end else if (accept) begin
                if (misaligned) begin
                    lsu_misalign <= 1'b1;
                    lsu_badaddr  <= ex_alu_out;
                end else begin
                    state      <= BUSY;
                    dmem_we    <= is_store;
                    dmem_be    <= be;
                    dmem_addr  <= {ex_alu_out[31:2], 2'b00};
                    dmem_wdata <= wdata;
                    func3      <= ex_func3;
                    off        <= ex_alu_out[1:0];
                    rd         <= ex_rd;
                end
            end
        end
    end
endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Memory-stage load/store unit sitting directly downstream of the EX-stage ALU. It takes the ALU's address result (base plus offset for LOAD/STORE) with the store data and destination register, and runs one data-memory transaction through a ready handshake. It generates word-aligned addresses, byte enables and replicated store data, and aligns and sign/zero-extends load data for write-back. It stalls the upstream pipeline while a transaction is outstanding and flags misaligned accesses.

## Interface
- No parameters; all datapaths fixed at 32 bits, opcode field 5 bits (instruction bits [6:2]).
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- ex_valid  in  1  EX stage presents a valid instruction this cycle
- ex_opcode  in  5  instruction opcode; LOAD = 5'b00000, STORE = 5'b01000; all others ignored
- ex_func3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores)
- ex_alu_out  in  32  effective byte address from ALU
- ex_rs2_data  in  32  store data
- ex_rd  in  5  load destination register
- lsu_stall  out  1  hold EX and earlier stages
- dmem_req  out  1  memory request valid
- dmem_we  out  1  1 = write, 0 = read
- dmem_be  out  4  byte enables, bit i = byte lane i
- dmem_addr  out  32  word address, bits [1:0] always 0
- dmem_wdata  out  32  lane-replicated store data
- dmem_ready  in  1  memory accepts/completes request this cycle; dmem_rdata valid same cycle
- dmem_rdata  in  32  read data
- wb_valid  out  1  one-cycle pulse: load result valid
- wb_rd  out  5  load destination register
- wb_data  out  32  aligned, extended load result
- lsu_misalign  out  1  one-cycle pulse: misaligned access dropped
- lsu_badaddr  out  32  faulting byte address, valid with lsu_misalign

## Operation
- States: IDLE, BUSY.
- IDLE, accept condition: ex_valid & opcode is LOAD or STORE & func3 legal for that opcode. Illegal func3 or other opcodes: no action, no flag.
- Alignment check at accept: W needs addr[1:0]==0; H/HU needs addr[0]==0; bytes always aligned.
- Aligned accept: register addr, func3, rd, we, be, wdata; go to BUSY.
- Misaligned accept: stay IDLE; next cycle lsu_misalign=1, lsu_badaddr=address; no dmem_req, no wb_valid.
- BUSY: dmem_req=1 with all dmem_* outputs held stable. On dmem_ready=1: loads capture extracted data and assert wb_valid next cycle; stores complete silently. Then return to IDLE.
- Byte enables: B = 4'b0001 << addr[1:0]; H = addr[1] ? 4'b1100 : 4'b0011; W = 4'b1111; same rule for loads.
- Store data: B = {4{rs2[7:0]}}, H = {2{rs2[15:0]}}, W = rs2.
- Load extraction: shift dmem_rdata right by 8*addr[1:0]; LB/LH sign-extend from bit 7/15, LBU/LHU zero-extend, LW unchanged.
- Load to rd=0: wb_valid still pulses with wb_rd=0; register file discards.
- lsu_stall = (state == BUSY). Accept cycle does not stall.

## Timing
- Reset (rst_n=0 at a clock edge): state IDLE; lsu_stall, dmem_req, dmem_we, wb_valid, lsu_misalign = 0; dmem_be = 0; dmem_addr, dmem_wdata, wb_rd, wb_data, lsu_badaddr = 0.
- Reset mid-transaction abandons it: dmem_req low from the reset edge, no wb_valid.
- Accept at edge T: dmem_req high from T through the edge where dmem_ready is sampled high (T+k, k>=1).
- wb_valid is high for exactly the cycle after T+k; minimum load latency is 2 cycles from accept to wb_valid.
- No new accept while BUSY. EX inputs are ignored during BUSY because upstream is stalled.
- An accept is allowed in the same cycle wb_valid or lsu_misalign pulses, so back-to-back operations run at one per (k+1) cycles.
- dmem_ready while IDLE is ignored.

## Test plan
- LW at addr 0x100, dmem_ready one cycle after req, rdata=0xDEADBEEF: be=1111, addr=0x100, stall for 1 cycle, then wb_valid with wb_data=0xDEADBEEF.
- LB addr 0x103, rdata=0x80FF0000: be=1000, wb_data=0xFFFFFF80. LBU at the same address returns 0x00000080. LHU at addr 0x102 returns 0x000080FF.
- SB addr 0x201, rs2=0x123456AB: dmem_we=1, be=0010, addr=0x200, wdata=0xABABABAB, no wb_valid. SH addr 0x202: be=1100, wdata=0x56AB56AB.
- LW addr 0x105: no dmem_req, lsu_misalign pulse with lsu_badaddr=0x105, no stall.
- dmem_ready held low 5 cycles: dmem_* outputs stable, lsu_stall high for all 5 cycles, single wb_valid after ready.
- rst_n asserted while BUSY: all outputs 0 after the edge, no wb_valid. A following LW completes normally.
